// File: rtl/zorro_arb_pkg.sv
// rtl/zorro_arb_pkg.sv - shared state encoding and parameter checks for the Zorro bus arbiter
package zorro_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_GRANT    = 3'd2,
    ST_DMA      = 3'd3,
    ST_RELEASE  = 3'd4,
    ST_COOLDOWN = 3'd5
  } arb_state_t;

  localparam int unsigned SLOT_W = 4;

  function automatic bit arb_params_ok(input int sync_stages, input int grant_timeout,
                                       input int cpu_slots, input int cnt_w);
    return (sync_stages >= 2) && (grant_timeout >= 2) && (grant_timeout <= 255) &&
           (cpu_slots >= 1) && (cpu_slots <= 15) && (cnt_w >= 1);
  endfunction

endpackage

// File: rtl/zorro_bus_arbiter_sync_chain.sv
// rtl/zorro_bus_arbiter_sync_chain.sv - multi-flop synchronizer for asynchronous bus strobes
module sync_chain #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
    end
  end

  assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/zorro_bus_arbiter.sv
// rtl/zorro_bus_arbiter.sv - BR/BG/BGACK arbiter between the local 68SEC000 and a motherboard DMA master
module zorro_bus_arbiter
  import zorro_arb_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int GRANT_TIMEOUT = 64,
  parameter int CPU_SLOTS     = 4,
  parameter int CNT_W         = 16
) (
  input  logic             C7M,
  input  logic             RESET_n,
  input  logic             DMA_EN,
  input  logic             BR_n_IN,
  input  logic             BGACK_n,
  input  logic             AS_n,
  input  logic             BG_68SEC000_n,
  output logic             BR_68SEC000_n,
  output logic             BG_n_OUT,
  output logic             BG_n_OE,
  output logic             DMA_ACTIVE,
  output logic             ARB_TIMEOUT,
  output logic [CNT_W-1:0] GRANT_COUNT
);

  localparam int TMR_W = $clog2(GRANT_TIMEOUT);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(GRANT_TIMEOUT - 1);
  localparam logic [SLOT_W-1:0] SLOT_LOAD = SLOT_W'(CPU_SLOTS - 1);

  if (!arb_params_ok(SYNC_STAGES, GRANT_TIMEOUT, CPU_SLOTS, CNT_W)) begin : g_bad_params
    $error("zorro_bus_arbiter: parameter out of range");
  end

  logic br_s, bgack_s, as_s, bg_cpu_s;

  sync_chain #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_br (
    .clk(C7M), .reset_n(RESET_n), .din(BR_n_IN), .dout(br_s));
  sync_chain #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_bgack (
    .clk(C7M), .reset_n(RESET_n), .din(BGACK_n), .dout(bgack_s));
  sync_chain #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_as (
    .clk(C7M), .reset_n(RESET_n), .din(AS_n), .dout(as_s));
  sync_chain #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_bg_cpu (
    .clk(C7M), .reset_n(RESET_n), .din(BG_68SEC000_n), .dout(bg_cpu_s));

  arb_state_t        state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              timeout_d;
  logic              count_inc;
  logic              br_cpu_d, bg_out_d, dma_active_d;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    slot_d    = slot_q;
    timeout_d = 1'b0;
    count_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!br_s && DMA_EN) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (!DMA_EN) begin
          state_d = ST_IDLE;
        end else if (!bg_cpu_s) begin
          state_d = ST_GRANT;
          timer_d = '0;
        end else if (br_s) begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        // BGACK wins over a simultaneous BR release; AS low means the CPU cycle is still finishing
        if (!bgack_s && as_s) begin
          state_d = ST_DMA;
        end else if (br_s && bgack_s) begin
          state_d = ST_RELEASE;
        end else if (timer_q == TMR_LAST) begin
          state_d   = ST_RELEASE;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_DMA: begin
        if (bgack_s) begin
          state_d   = ST_RELEASE;
          count_inc = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (bg_cpu_s) begin
          state_d = ST_COOLDOWN;
          slot_d  = SLOT_LOAD;
        end
      end
      ST_COOLDOWN: begin
        if (slot_q == '0) state_d = ST_IDLE;
        else              slot_d  = slot_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    br_cpu_d     = !(state_d inside {ST_REQ, ST_GRANT, ST_DMA});
    bg_out_d     = (state_d != ST_GRANT);
    dma_active_d = (state_d == ST_DMA);
  end

  always_ff @(posedge C7M) begin
    if (!RESET_n) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      slot_q        <= '0;
      BR_68SEC000_n <= 1'b1;
      BG_n_OUT      <= 1'b1;
      BG_n_OE       <= 1'b0;
      DMA_ACTIVE    <= 1'b0;
      ARB_TIMEOUT   <= 1'b0;
      GRANT_COUNT   <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      slot_q        <= slot_d;
      BR_68SEC000_n <= br_cpu_d;
      BG_n_OUT      <= bg_out_d;
      BG_n_OE       <= DMA_EN;
      DMA_ACTIVE    <= dma_active_d;
      ARB_TIMEOUT   <= timeout_d;
      if (count_inc && (GRANT_COUNT != '1)) GRANT_COUNT <= GRANT_COUNT + 1'b1;
    end
  end

endmodule

// File: tb/tb_zorro_bus_arbiter.sv
// tb/tb_zorro_bus_arbiter.sv - scoreboard bench for the Zorro bus arbiter
module tb_zorro_bus_arbiter;

  localparam int SYNC_STAGES   = 2;
  localparam int GRANT_TIMEOUT = 64;
  localparam int CPU_SLOTS     = 4;
  localparam int CNT_W         = 2;
  localparam int CNT_MAX       = (1 << CNT_W) - 1;
  // CPU drops BG the cycle BR rises: RELEASE lasts the sync delay plus one, then cooldown, then one IDLE cycle
  localparam int GAP           = SYNC_STAGES + 1 + CPU_SLOTS + 1;

  localparam int W_BR = 0, W_BG = 1, W_DMA = 2, W_TMO = 3;

  logic C7M = 1'b0;
  logic RESET_n, DMA_EN, BR_n_IN, BGACK_n, AS_n, BG_68SEC000_n;
  logic BR_68SEC000_n, BG_n_OUT, BG_n_OE, DMA_ACTIVE, ARB_TIMEOUT;
  logic [CNT_W-1:0] GRANT_COUNT;

  typedef struct {
    int cnt;
    int len;
  } tenure_t;

  tenure_t sb_q[$];
  int      gap_q[$];
  int      tmo_q[$];
  tenure_t sb_item;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;
  int tmo_seen = 0;
  int bg_total = 0;
  int br_falls = 0;
  int bg_run = 0, bg_last = 0, br_run = 0, dma_run = 0;
  logic dma_prev = 1'b0, br_prev = 1'b1, bg_prev = 1'b1;
  int cpu_cnt = 0;

  zorro_bus_arbiter #(
    .SYNC_STAGES(SYNC_STAGES), .GRANT_TIMEOUT(GRANT_TIMEOUT),
    .CPU_SLOTS(CPU_SLOTS), .CNT_W(CNT_W)
  ) dut (
    .C7M(C7M), .RESET_n(RESET_n), .DMA_EN(DMA_EN), .BR_n_IN(BR_n_IN),
    .BGACK_n(BGACK_n), .AS_n(AS_n), .BG_68SEC000_n(BG_68SEC000_n),
    .BR_68SEC000_n(BR_68SEC000_n), .BG_n_OUT(BG_n_OUT), .BG_n_OE(BG_n_OE),
    .DMA_ACTIVE(DMA_ACTIVE), .ARB_TIMEOUT(ARB_TIMEOUT), .GRANT_COUNT(GRANT_COUNT)
  );

  always #5 C7M = ~C7M;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge C7M);
    #2;
  endtask

  task automatic wait_for(input string tag, input int sel, input logic lvl, input int max, output int n);
    logic v;
    n = 0;
    forever begin
      @(negedge C7M);
      case (sel)
        W_BR:    v = BR_68SEC000_n;
        W_BG:    v = BG_n_OUT;
        W_DMA:   v = DMA_ACTIVE;
        default: v = ARB_TIMEOUT;
      endcase
      if (v == lvl) break;
      n++;
      if (n > max) begin
        check_eq({tag, "_wait"}, n, max);
        break;
      end
    end
  endtask

  task automatic dma_tenure(input int hold, input bit drop_br);
    int n;
    wait_for("bg_low", W_BG, 1'b0, 80, n);
    tick(1);
    BGACK_n = 1'b0;
    if (drop_br) BR_n_IN = 1'b1;
    tick(hold);
    BGACK_n = 1'b1;
  endtask

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  // local 68SEC000: grants three cycles after BR, drops BG as soon as BR goes away
  initial begin
    BG_68SEC000_n = 1'b1;
    forever begin
      @(posedge C7M);
      #2;
      if (BR_68SEC000_n) begin
        BG_68SEC000_n = 1'b1;
        cpu_cnt = 0;
      end else if (cpu_cnt >= 3) begin
        BG_68SEC000_n = 1'b0;
      end else begin
        cpu_cnt++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge C7M);
      if (!BG_n_OUT) begin
        bg_run++;
        bg_total++;
      end else if (!bg_prev) begin
        bg_last = bg_run;
        bg_run  = 0;
      end
      if (ARB_TIMEOUT) begin
        tmo_seen++;
        if (tmo_q.size() == 0) check_eq("tmo_unexpected", 1, 0);
        else                   check_eq("grant_len", bg_last, tmo_q.pop_front());
      end
      if (DMA_ACTIVE) begin
        dma_run++;
      end else if (dma_prev) begin
        if (sb_q.size() == 0) begin
          check_eq("tenure_unexpected", 1, 0);
        end else begin
          sb_item = sb_q.pop_front();
          check_eq("tenure_count", GRANT_COUNT, sb_item.cnt);
          check_eq("tenure_len", dma_run, sb_item.len);
          check_eq("br_after_dma", BR_68SEC000_n, 1);
        end
        dma_run = 0;
      end
      if (BR_68SEC000_n) begin
        br_run++;
      end else if (br_prev) begin
        br_falls++;
        if (gap_q.size() != 0) check_eq("cpu_gap", br_run, gap_q.pop_front());
        br_run = 0;
      end
      dma_prev = DMA_ACTIVE;
      br_prev  = BR_68SEC000_n;
      bg_prev  = BG_n_OUT;
    end
  end

  initial begin
    int n;
    int bg_before, falls_before;

    RESET_n = 1'b0; DMA_EN = 1'b1; BR_n_IN = 1'b0; BGACK_n = 1'b1; AS_n = 1'b1;
    tick(3);
    @(negedge C7M);
    check_eq("rst_br_cpu", BR_68SEC000_n, 1);
    check_eq("rst_bg_out", BG_n_OUT, 1);
    check_eq("rst_bg_oe", BG_n_OE, 0);
    check_eq("rst_dma", DMA_ACTIVE, 0);
    check_eq("rst_tmo", ARB_TIMEOUT, 0);
    check_eq("rst_count", GRANT_COUNT, 0);
    tick(1);
    RESET_n = 1'b1; BR_n_IN = 1'b1;
    tick(4);
    @(negedge C7M);
    check_eq("oe_after_rst", BG_n_OE, 1);
    check_eq("br_idle", BR_68SEC000_n, 1);

    // foreign master in IDLE, then arbitration disabled with a pending request
    tick(1);
    BGACK_n = 1'b0;
    tick(6);
    @(negedge C7M);
    check_eq("foreign_dma", DMA_ACTIVE, 0);
    check_eq("foreign_br", BR_68SEC000_n, 1);
    tick(1);
    BGACK_n = 1'b1; DMA_EN = 1'b0; BR_n_IN = 1'b0;
    tick(6);
    @(negedge C7M);
    check_eq("dis_br", BR_68SEC000_n, 1);
    check_eq("dis_oe", BG_n_OE, 0);
    tick(1);
    BR_n_IN = 1'b1; DMA_EN = 1'b1;
    tick(6);

    // full tenure
    BR_n_IN = 1'b0;
    wait_for("br_req", W_BR, 1'b0, 10, n);
    check_eq("br_latency", n, SYNC_STAGES + 1);
    exp_cnt = sat_inc(exp_cnt);
    sb_q.push_back('{exp_cnt, 10});
    dma_tenure(10, 1'b1);
    tick(20);
    @(negedge C7M);
    check_eq("count_full", GRANT_COUNT, exp_cnt);

    // grant timeout with request held, then a re-request after the fairness window
    tick(1);
    tmo_q.push_back(GRANT_TIMEOUT);
    BR_n_IN = 1'b0;
    wait_for("tmo", W_TMO, 1'b1, GRANT_TIMEOUT + 40, n);
    gap_q.push_back(GAP);
    wait_for("rereq", W_BR, 1'b0, 40, n);
    tick(1);
    BR_n_IN = 1'b1;
    tick(20);
    @(negedge C7M);
    check_eq("count_tmo", GRANT_COUNT, exp_cnt);
    check_eq("tmo_pulses", tmo_seen, 1);

    // withdrawn request
    bg_before = bg_total;
    falls_before = br_falls;
    tick(1);
    BR_n_IN = 1'b0;
    tick(2);
    BR_n_IN = 1'b1;
    tick(12);
    @(negedge C7M);
    check_eq("wd_req_seen", br_falls - falls_before, 1);
    check_eq("wd_bg_never", bg_total - bg_before, 0);
    check_eq("wd_br_cpu", BR_68SEC000_n, 1);

    // BGACK while the CPU cycle is still running
    tick(1);
    AS_n = 1'b0; BR_n_IN = 1'b0;
    wait_for("bg_low_as", W_BG, 1'b0, 40, n);
    tick(1);
    BGACK_n = 1'b0;
    tick(5);
    @(negedge C7M);
    check_eq("as_hold_dma", DMA_ACTIVE, 0);
    check_eq("as_hold_grant", BG_n_OUT, 0);
    tick(1);
    AS_n = 1'b1;
    wait_for("as_dma", W_DMA, 1'b1, 10, n);
    check_eq("as_dma_latency", n, SYNC_STAGES + 1);
    exp_cnt = sat_inc(exp_cnt);
    sb_q.push_back('{exp_cnt, 4 + SYNC_STAGES + 1});
    tick(4);
    BGACK_n = 1'b1; BR_n_IN = 1'b1;
    tick(20);

    // fresh counter, back-to-back tenures into saturation
    RESET_n = 1'b0; BR_n_IN = 1'b0;
    tick(3);
    @(negedge C7M);
    check_eq("rst2_count", GRANT_COUNT, 0);
    check_eq("rst2_br_cpu", BR_68SEC000_n, 1);
    tick(1);
    RESET_n = 1'b1;
    exp_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      exp_cnt = sat_inc(exp_cnt);
      sb_q.push_back('{exp_cnt, 4});
      dma_tenure(4, 1'b0);
      if (i < 4) gap_q.push_back(GAP);
    end
    BR_n_IN = 1'b1;
    tick(30);
    @(negedge C7M);
    check_eq("count_sat", GRANT_COUNT, CNT_MAX);
    check_eq("sb_left", sb_q.size(), 0);
    check_eq("gap_left", gap_q.size(), 0);
    check_eq("tmo_left", tmo_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
